axi4lite_reg_bank: RTL
======================

// Module: axi4lite_reg_bank
// PURPOSE
//   AXI4-Lite slave endpoint terminating transactions forwarded by the register station's master port.
//   Holds NUM_REGS read/write control registers, exposed flat to fabric logic with per-register write strobes.
//   One outstanding write and one outstanding read; both run concurrently.
//   Decode errors return SLVERR.
// PARAMETERS
//   ADDR_WIDTH  32  AXI address width
//   DATA_WIDTH  32  AXI data width, 32 or 64
//   NUM_REGS    16  number of registers, power of 2, >=2
//   RESET_VAL   0   reset value of every register (DATA_WIDTH bits)
// PORTS
//   aclk           in   1                    clock; all logic on rising edge
//   aresetn        in   1                    asynchronous active-low reset
//   s_axi_awaddr   in   ADDR_WIDTH           write address
//   s_axi_awprot   in   3                    write protection
//   s_axi_awvalid  in   1                    AW valid
//   s_axi_awready  out  1                    AW ready
//   s_axi_wdata    in   DATA_WIDTH           write data
//   s_axi_wstrb    in   DATA_WIDTH/8         byte strobes
//   s_axi_wvalid   in   1                    W valid
//   s_axi_wready   out  1                    W ready
//   s_axi_bresp    out  2                    write response
//   s_axi_bvalid   out  1                    B valid
//   s_axi_bready   in   1                    B ready
//   s_axi_araddr   in   ADDR_WIDTH           read address
//   s_axi_arprot   in   3                    read protection
//   s_axi_arvalid  in   1                    AR valid
//   s_axi_arready  out  1                    AR ready
//   s_axi_rdata    out  DATA_WIDTH           read data
//   s_axi_rresp    out  2                    read response
//   s_axi_rvalid   out  1                    R valid
//   s_axi_rready   in   1                    R ready
//   reg_o          out  NUM_REGS*DATA_WIDTH  register contents; reg k at [k*DATA_WIDTH +: DATA_WIDTH]
//   reg_wr_o       out  NUM_REGS             1-cycle pulse, registered with the update of reg k
// BEHAVIOUR
//   Reset:
//   - aclk, async active-low aresetn.
//   - Reset clears bvalid, rvalid, reg_wr_o, rdata, bresp, rresp, aw_held, w_held.
//   - All registers reset to RESET_VAL; awready, wready and arready read 1.
//   - Mid-transaction reset drops the transaction silently.
//   Decode:
//   - idx = addr[$clog2(DATA_WIDTH/8) +: $clog2(NUM_REGS)].
//   - Any nonzero address bit above idx -> SLVERR (2'b10), no side effect.
//   - Low byte-offset bits are ignored.
//   Write channel (AW/W in any order):
//   - awready = ~aw_held & ~bvalid; wready = ~w_held & ~bvalid.
//   - A handshake captures addr/prot or data/strb and sets the held flag.
//   - Edge after both flags are 1 (commit edge):
//     - Update bytes i of reg idx where wstrb[i]=1.
//     - Pulse reg_wr_o[idx] for one cycle (OKAY only, even if wstrb=0).
//     - Set bvalid=1 with bresp.
//     - Clear both held flags.
//   - Latency: AW and W accepted on edge E0 -> bvalid and new reg_o after E1.
//   - bvalid holds, with bresp stable, until the bvalid & bready edge.
//   - A second AW may not be accepted until B completes.
//   - AW arriving cycles before W (or W before AW) waits indefinitely; no timeout.
//   Read channel:
//   - arready = ~rvalid.
//   - On an AR handshake edge, register rdata = reg[idx] (0 on error) and rresp; set rvalid=1.
//   - Latency 1.
//   - rvalid/rdata/rresp hold until the rvalid & rready edge.
//   - If a read handshake and a write commit to the same reg hit the same edge, the read returns the OLD value.
//   - Back-to-back reads: the next AR is accepted on the edge after R completes.
//   Responses: OKAY 2'b00, SLVERR 2'b10; EXOKAY/DECERR never issued.
// CONFIGURATION
//   AXI4LITE_REG_BANK_PROT_CHECK_EN:
//   - Defined: awprot[0]==0 or arprot[0]==0 (unprivileged) -> SLVERR.
//     - Such a write has no register update and no reg_wr_o pulse.
//     - Such a read returns rdata=0.
//   - Undefined: prot is captured but ignored; all decoded accesses return OKAY.
// STRUCTURE
//   Package axi4lite_pkg:
//   - typedef enum logic[1:0] axi_resp_e {RESP_OKAY=2'b00, RESP_EXOKAY, RESP_SLVERR, RESP_DECERR}.
//   - Function strb_merge(old, data, strb).
//   Sub-module axi4lite_aw_w_join:
//   - Joins AW and W into one write command (held flags, capture registers, ready logic).
//   - Ports: cmd_valid/cmd_ready toward the bank.
//   Decode, register array and R path stay in the top module.
// TESTING
//   1. Reset, then AW 0x08 and W 0xDEADBEEF strb 0xF together.
//      -> bvalid 2 cycles later, bresp=00, reg_wr_o[2] pulses once.
//      -> Read 0x08 returns 0xDEADBEEF, OKAY.
//   2. W 0x000000AA strb 0x1 three cycles before AW 0x04; reg1 previously 0x11223344.
//      -> wready drops after the W handshake; bvalid only after the AW handshake.
//      -> reg1 = 0x112233AA.
//   3. Hold bready=0 for 5 cycles after a write.
//      -> bvalid and bresp stable; awready=wready=0 throughout; next AW accepted after the B handshake.
//   4. Write 0x40 with NUM_REGS=16, and read 0x1000.
//      -> SLVERR on both, no reg_wr_o pulse, rdata=0, registers unchanged.
//   5. Read reg3 on the write-commit edge of 0x55 to reg3 (old value 0x0).
//      -> rdata=0x0; a subsequent read returns 0x55.
//   6. Assert aresetn low while bvalid=1 and rvalid=1.
//      -> Both drop asynchronously; all reg_o = RESET_VAL.
//      -> With PROT_CHECK_EN defined, awprot=3'b000 write -> SLVERR.

Source files
------------

// File: rtl/axi4lite_pkg.sv
// Shared AXI4-Lite types and helpers for the register bank.
package axi4lite_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_e;

  // Byte-lane merge of one 32-bit word: lanes with strb set take the new data.
  function automatic logic [31:0] strb_merge(input logic [31:0] old,
                                             input logic [31:0] data,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[i*8 +: 8] = strb[i] ? data[i*8 +: 8] : old[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axi4lite_aw_w_join.sv
// Joins the AXI4-Lite AW and W channels into a single write command.
// Each channel is accepted independently and held until both are present;
// the command is consumed by the bank on the cmd_valid & cmd_ready edge.
module axi4lite_aw_w_join
  import axi4lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [ADDR_WIDTH-1:0]     awaddr,
  input  logic [2:0]                awprot,
  input  logic                      awvalid,
  output logic                      awready,
  input  logic [DATA_WIDTH-1:0]     wdata,
  input  logic [DATA_WIDTH/8-1:0]   wstrb,
  input  logic                      wvalid,
  output logic                      wready,
  input  logic                      busy,
  output logic                      cmd_valid,
  input  logic                      cmd_ready,
  output logic [ADDR_WIDTH-1:0]     cmd_addr,
  output logic [2:0]                cmd_prot,
  output logic [DATA_WIDTH-1:0]     cmd_data,
  output logic [DATA_WIDTH/8-1:0]   cmd_strb
);

  logic aw_held;
  logic w_held;

  // A channel stays blocked while its beat is held or a B response is pending.
  assign awready   = ~aw_held & ~busy;
  assign wready    = ~w_held & ~busy;
  assign cmd_valid = aw_held & w_held;

  // Held flags: set on each channel handshake, cleared together on commit.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
    end else if (cmd_valid && cmd_ready) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
    end else begin
      if (awvalid && awready) aw_held <= 1'b1;
      if (wvalid && wready)   w_held  <= 1'b1;
    end
  end

  // Capture registers are data only; their content is qualified by the held flags.
  always_ff @(posedge aclk) begin
    if (awvalid && awready) begin
      cmd_addr <= awaddr;
      cmd_prot <= awprot;
    end
    if (wvalid && wready) begin
      cmd_data <= wdata;
      cmd_strb <= wstrb;
    end
  end

endmodule

// File: rtl/axi4lite_reg_bank.sv
// AXI4-Lite slave register bank: NUM_REGS read/write registers exposed flat
// on reg_o with a one-cycle reg_wr_o pulse per committed write.
// One write and one read may be outstanding at once, running concurrently.
// Optional macro AXI4LITE_REG_BANK_PROT_CHECK_EN: unprivileged accesses
// (prot[0]==0) answer SLVERR with no side effect and zero read data.
module axi4lite_reg_bank
  import axi4lite_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_REGS   = 16,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  input  logic [ADDR_WIDTH-1:0]          s_axi_awaddr,
  input  logic [2:0]                     s_axi_awprot,
  input  logic                           s_axi_awvalid,
  output logic                           s_axi_awready,
  input  logic [DATA_WIDTH-1:0]          s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]        s_axi_wstrb,
  input  logic                           s_axi_wvalid,
  output logic                           s_axi_wready,
  output logic [1:0]                     s_axi_bresp,
  output logic                           s_axi_bvalid,
  input  logic                           s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]          s_axi_araddr,
  input  logic [2:0]                     s_axi_arprot,
  input  logic                           s_axi_arvalid,
  output logic                           s_axi_arready,
  output logic [DATA_WIDTH-1:0]          s_axi_rdata,
  output logic [1:0]                     s_axi_rresp,
  output logic                           s_axi_rvalid,
  input  logic                           s_axi_rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_o,
  output logic [NUM_REGS-1:0]            reg_wr_o
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(NUM_REGS);
  localparam int WORDS  = DATA_WIDTH / 32;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic                  bvalid;
  axi_resp_e             bresp;
  logic                  rvalid;
  axi_resp_e             rresp;

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [2:0]            cmd_prot;
  logic [DATA_WIDTH-1:0] cmd_data;
  logic [STRB_W-1:0]     cmd_strb;

  logic                  commit;
  logic [IDX_W-1:0]      wr_idx;
  logic                  wr_err;
  logic                  wr_prot_err;
  logic [DATA_WIDTH-1:0] wr_merged;
  logic [IDX_W-1:0]      rd_idx;
  logic                  rd_err;
  logic                  rd_prot_err;
  logic                  unused_ok;

  axi4lite_aw_w_join #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_join (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .awaddr    (s_axi_awaddr),
    .awprot    (s_axi_awprot),
    .awvalid   (s_axi_awvalid),
    .awready   (s_axi_awready),
    .wdata     (s_axi_wdata),
    .wstrb     (s_axi_wstrb),
    .wvalid    (s_axi_wvalid),
    .wready    (s_axi_wready),
    .busy      (bvalid),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_prot  (cmd_prot),
    .cmd_data  (cmd_data),
    .cmd_strb  (cmd_strb)
  );

`ifdef AXI4LITE_REG_BANK_PROT_CHECK_EN
  assign wr_prot_err = ~cmd_prot[0];
  assign rd_prot_err = ~s_axi_arprot[0];
`else
  assign wr_prot_err = 1'b0;
  assign rd_prot_err = 1'b0;
`endif

  // Byte-offset bits and (when unchecked) prot are intentionally ignored.
  assign unused_ok = ^{cmd_prot, s_axi_arprot, cmd_addr[OFF_W-1:0], s_axi_araddr[OFF_W-1:0]};

  // Decode: index bits select the register, any higher set bit is an error.
  assign wr_idx      = cmd_addr[OFF_W +: IDX_W];
  assign wr_err      = (|(cmd_addr >> (OFF_W + IDX_W))) | wr_prot_err;
  assign rd_idx      = s_axi_araddr[OFF_W +: IDX_W];
  assign rd_err      = (|(s_axi_araddr >> (OFF_W + IDX_W))) | rd_prot_err;

  // The bank takes a joined command whenever no B response is pending.
  assign cmd_ready   = ~bvalid;
  assign commit      = cmd_valid & cmd_ready;

  // Byte-strobe merge of the target register, one 32-bit word at a time.
  always_comb begin
    wr_merged = regs[wr_idx];
    for (int w = 0; w < WORDS; w++) begin
      wr_merged[w*32 +: 32] = strb_merge(regs[wr_idx][w*32 +: 32],
                                         cmd_data[w*32 +: 32],
                                         cmd_strb[w*4 +: 4]);
    end
  end

  // Write commit: update register, pulse reg_wr_o, raise B; B clears on handshake.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int k = 0; k < NUM_REGS; k++) regs[k] <= RESET_VAL;
      reg_wr_o <= '0;
      bvalid   <= 1'b0;
      bresp    <= RESP_OKAY;
    end else begin
      reg_wr_o <= '0;
      if (commit) begin
        bvalid <= 1'b1;
        bresp  <= wr_err ? RESP_SLVERR : RESP_OKAY;
        if (!wr_err) begin
          regs[wr_idx]     <= wr_merged;
          reg_wr_o[wr_idx] <= 1'b1;
        end
      end else if (bvalid && s_axi_bready) begin
        bvalid <= 1'b0;
      end
    end
  end

  // Read path: sample the pre-edge register value on AR, hold until R handshake.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rvalid      <= 1'b0;
      s_axi_rdata <= '0;
      rresp       <= RESP_OKAY;
    end else if (s_axi_arvalid && s_axi_arready) begin
      rvalid      <= 1'b1;
      s_axi_rdata <= rd_err ? '0 : regs[rd_idx];
      rresp       <= rd_err ? RESP_SLVERR : RESP_OKAY;
    end else if (rvalid && s_axi_rready) begin
      rvalid <= 1'b0;
    end
  end

  assign s_axi_arready = ~rvalid;
  assign s_axi_rvalid  = rvalid;
  assign s_axi_rresp   = rresp;
  assign s_axi_bvalid  = bvalid;
  assign s_axi_bresp   = bresp;

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg_out
    assign reg_o[k*DATA_WIDTH +: DATA_WIDTH] = regs[k];
  end

endmodule
